// File: rtl/zorro_slave_ctrl.sv
// ---------------------------------------------------------------------------
// zorro_slave_ctrl
//
// Zorro III slave-cycle controller for the A4092 SCSI card. Host strobes and
// the NCR acknowledge arrive asynchronously and are brought into the CLK
// domain through two-flop synchronisers. A falling full-cycle strobe inside
// the SCSI register window starts a cycle: address and direction are
// latched, the NCR chip select is raised once a data strobe is seen, and
// DTACK_n is returned to the host on NCR acknowledge or on a forced timeout.
// All handshake outputs are registered so the downstream buffer logic sees
// clean, glitch-free levels.
// ---------------------------------------------------------------------------

// Two-flop synchroniser with a selectable reset level.
module zorro_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments let both stages sample their
            // inputs from before the edge, which is what makes this a
            // two-stage pipeline rather than a single wire.
            meta <= d;
            q    <= meta;
        end
    end

endmodule


module zorro_slave_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FCS_n,
    input  logic [3:0] DS_n,
    input  logic       READ,
    input  logic [6:0] ADDR,
    input  logic       configured,
    input  logic       NCR_ACK_n,
    output logic       slave_cycle,
    output logic       read_latched,
    output logic [6:0] addr_latched,
    output logic       NCR_CS_n,
    output logic       DTACK_n,
    output logic       timeout
);

    // SCSI register window on address bits [23:17].
    localparam logic [6:0] REGION_LO = 7'h40;
    localparam logic [6:0] REGION_HI = 7'h43;

    // Counter value on which the access is force-terminated; the counter is
    // cleared on the NCR_ACCESS entry edge, so matching CYCLES-1 lands the
    // DTACK_n edge exactly TIMEOUT_CYCLES edges after entry.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_DS    = 2'd1,
        S_NCR_ACCESS = 2'd2,
        S_ACK        = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] count;

    // Synchronised strobes (all active-low, all reset to the idle level).
    logic fcs_sync;
    logic ds_sync;
    logic ack_sync;
    logic fcs_prev;

    // Start-up qualification of the FCS edge detector.
    logic [1:0] sync_fill;
    logic       fcs_armed;

    // Decoded conditions.
    logic region_hit;
    logic fcs_fall;
    logic fcs_high;
    logic ds_asserted;
    logic ack_asserted;

    // Any single data strobe low counts as a data strobe, so the four are
    // ANDed before synchronisation and only one bit crosses domains.
    logic ds_all_n;
    assign ds_all_n = &DS_n;

    zorro_sync2 #(.RESET_VALUE(1'b1)) u_sync_fcs (
        .clk (CLK),
        .rst (RESET),
        .d   (FCS_n),
        .q   (fcs_sync)
    );

    zorro_sync2 #(.RESET_VALUE(1'b1)) u_sync_ds (
        .clk (CLK),
        .rst (RESET),
        .d   (ds_all_n),
        .q   (ds_sync)
    );

    zorro_sync2 #(.RESET_VALUE(1'b1)) u_sync_ack (
        .clk (CLK),
        .rst (RESET),
        .d   (NCR_ACK_n),
        .q   (ack_sync)
    );

    // Previous synced FCS_n for edge detection, plus an arming flag. The sync
    // flops come out of reset high, so a strobe that is still low when reset
    // releases would look like a fresh falling edge. The detector is armed
    // only once FCS_n has been genuinely sampled high after the synchroniser
    // has flushed its reset value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fcs_prev  <= 1'b1;
            sync_fill <= 2'b00;
            fcs_armed <= 1'b0;
        end else begin
            fcs_prev  <= fcs_sync;
            sync_fill <= {sync_fill[0], 1'b1};
            fcs_armed <= fcs_armed | (sync_fill[1] & fcs_sync);
        end
    end

    // Cycle qualification and strobe decode.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        region_hit   = 1'b0;
        fcs_fall     = 1'b0;
        fcs_high     = fcs_sync;
        ds_asserted  = ~ds_sync;
        ack_asserted = ~ack_sync;

        // ADDR and configured are sampled directly: the host holds ADDR
        // stable across the synchroniser latency, and configured is static.
        if (configured && (ADDR >= REGION_LO) && (ADDR <= REGION_HI)) begin
            region_hit = 1'b1;
        end

        if (fcs_armed && fcs_prev && !fcs_sync) begin
            fcs_fall = 1'b1;
        end
    end

    // Slave-cycle sequencer with registered handshake outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            count        <= 8'd0;
            slave_cycle  <= 1'b0;
            read_latched <= 1'b0;
            addr_latched <= 7'h00;
            NCR_CS_n     <= 1'b1;
            DTACK_n      <= 1'b1;
            timeout      <= 1'b0;
        end else begin
            // The timeout flag is a single-cycle pulse unless re-asserted.
            timeout <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A region miss leaves everything, including the
                    // latched address and direction, untouched.
                    if (fcs_fall && region_hit) begin
                        addr_latched <= ADDR;
                        read_latched <= READ;
                        slave_cycle  <= 1'b1;
                        state        <= S_WAIT_DS;
                    end
                end

                S_WAIT_DS: begin
                    // A host abort wins over a data strobe seen on the
                    // same edge.
                    if (fcs_high) begin
                        slave_cycle <= 1'b0;
                        state       <= S_IDLE;
                    end else if (ds_asserted) begin
                        NCR_CS_n <= 1'b0;
                        count    <= 8'd0;
                        state    <= S_NCR_ACCESS;
                    end
                end

                S_NCR_ACCESS: begin
                    // Abort outranks ack, and a real ack outranks the
                    // forced termination when both land on one edge.
                    if (fcs_high) begin
                        slave_cycle <= 1'b0;
                        NCR_CS_n    <= 1'b1;
                        state       <= S_IDLE;
                    end else if (ack_asserted) begin
                        DTACK_n <= 1'b0;
                        state   <= S_ACK;
                    end else if (count == TIMEOUT_LAST) begin
                        DTACK_n <= 1'b0;
                        timeout <= 1'b1;
                        state   <= S_ACK;
                    end else begin
                        count <= count + 8'd1;
                    end
                end

                S_ACK: begin
                    // DTACK_n, NCR_CS_n and slave_cycle are held until the
                    // host ends the cycle by releasing FCS_n.
                    if (fcs_high) begin
                        slave_cycle <= 1'b0;
                        NCR_CS_n    <= 1'b1;
                        DTACK_n     <= 1'b1;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    slave_cycle <= 1'b0;
                    NCR_CS_n    <= 1'b1;
                    DTACK_n     <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zorro_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_zorro_slave_ctrl
//
// Directed stimulus for the Zorro III slave controller. Each stimulus step
// pushes the output changes it should cause, tagged with the clock edge on
// which they must appear, into a queue. A monitor watches the outputs on
// every falling clock edge and pops/compares one entry whenever any output
// changes; an output change with nothing queued is reported as unexpected.
// ---------------------------------------------------------------------------
module tb_zorro_slave_ctrl;

    localparam int T = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       FCS_n;
    logic [3:0] DS_n;
    logic       READ;
    logic [6:0] ADDR;
    logic       configured;
    logic       NCR_ACK_n;
    logic       slave_cycle;
    logic       read_latched;
    logic [6:0] addr_latched;
    logic       NCR_CS_n;
    logic       DTACK_n;
    logic       timeout;

    zorro_slave_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .FCS_n        (FCS_n),
        .DS_n         (DS_n),
        .READ         (READ),
        .ADDR         (ADDR),
        .configured   (configured),
        .NCR_ACK_n    (NCR_ACK_n),
        .slave_cycle  (slave_cycle),
        .read_latched (read_latched),
        .addr_latched (addr_latched),
        .NCR_CS_n     (NCR_CS_n),
        .DTACK_n      (DTACK_n),
        .timeout      (timeout)
    );

    always #5 CLK = ~CLK;

    // Rising-edge counter used to timestamp expected and observed events.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic       sc;
        logic       cs_n;
        logic       dt_n;
        logic       to;
        logic [6:0] addr;
        logic       rd;
    } obs_t;

    typedef struct {
        int   at;
        obs_t obs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int at, input logic sc, input logic cs_n, input logic dt_n,
                        input logic to, input logic [6:0] addr, input logic rd);
        exp_t e;
        e.at  = at;
        e.obs = '{sc: sc, cs_n: cs_n, dt_n: dt_n, to: to, addr: addr, rd: rd};
        exp_q.push_back(e);
    endtask

    // Wait n rising edges, then step 1 ns past the edge before driving.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Host starts a cycle with a data strobe already low: slave_cycle and
    // the latches appear 3 edges later, NCR_CS_n one edge after that.
    task automatic start_cycle(input logic [6:0] a, input logic rd, output int entry);
        ADDR  = a;
        READ  = rd;
        FCS_n = 1'b0;
        DS_n  = 4'h0;
        push(cyc + 3, 1'b1, 1'b1, 1'b1, 1'b0, a, rd);
        push(cyc + 4, 1'b1, 1'b0, 1'b1, 1'b0, a, rd);
        entry = cyc + 4;
    endtask

    // Host ends the cycle; all handshake outputs drop 3 edges later.
    task automatic end_cycle(input logic [6:0] a, input logic rd);
        FCS_n     = 1'b1;
        DS_n      = 4'hF;
        NCR_ACK_n = 1'b1;
        push(cyc + 3, 1'b0, 1'b1, 1'b1, 1'b0, a, rd);
    endtask

    // Monitor: compare every output change against the queue head.
    obs_t mon_prev;
    obs_t mon_cur;
    exp_t mon_e;
    initial begin
        mon_prev = '{sc: 1'b0, cs_n: 1'b1, dt_n: 1'b1, to: 1'b0, addr: 7'h00, rd: 1'b0};
        wait (mon_en);
        forever begin
            @(negedge CLK);
            mon_cur = {slave_cycle, NCR_CS_n, DTACK_n, timeout, addr_latched, read_latched};
            if (mon_cur !== mon_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_event: got 0x%0h at cycle %0d, expected no output change",
                             mon_cur, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(mon_e.at));
                    check("event_outputs", 32'(mon_cur), 32'(mon_e.obs));
                end
                mon_prev = mon_cur;
            end
        end
    end

    int entry;

    initial begin
        RESET      = 1'b1;
        FCS_n      = 1'b1;
        DS_n       = 4'hF;
        READ       = 1'b0;
        ADDR       = 7'h00;
        configured = 1'b1;
        NCR_ACK_n  = 1'b1;
        tick(3);

        // Reset values.
        check("rst_slave_cycle", 32'(slave_cycle), 32'd0);
        check("rst_read_latched", 32'(read_latched), 32'd0);
        check("rst_addr_latched", 32'(addr_latched), 32'h00);
        check("rst_ncr_cs_n", 32'(NCR_CS_n), 32'd1);
        check("rst_dtack_n", 32'(DTACK_n), 32'd1);
        check("rst_timeout", 32'(timeout), 32'd0);

        RESET  = 1'b0;
        mon_en = 1'b1;
        tick(5);

        // Read hit at 0x41: ack low 5 edges after NCR_CS_n falls, DTACK_n
        // two edges after the ack is first sampled.
        start_cycle(7'h41, 1'b1, entry);
        tick(entry + 4 - cyc);
        NCR_ACK_n = 1'b0;
        push(cyc + 3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h41, 1'b1);
        tick(4);
        end_cycle(7'h41, 1'b1);
        tick(5);

        // Region misses: just above the window, then in-window while
        // unconfigured. No output may move, latches included.
        ADDR  = 7'h44;
        READ  = 1'b0;
        FCS_n = 1'b0;
        DS_n  = 4'h0;
        tick(10);
        FCS_n = 1'b1;
        DS_n  = 4'hF;
        tick(5);
        configured = 1'b0;
        ADDR       = 7'h40;
        FCS_n      = 1'b0;
        DS_n       = 4'h0;
        tick(10);
        FCS_n = 1'b1;
        DS_n  = 4'hF;
        tick(5);
        configured = 1'b1;

        // Timeout: no ack, DTACK_n and a one-cycle timeout pulse exactly T
        // edges after NCR_ACCESS entry.
        start_cycle(7'h42, 1'b1, entry);
        push(entry + T, 1'b1, 1'b0, 1'b0, 1'b1, 7'h42, 1'b1);
        push(entry + T + 1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h42, 1'b1);
        tick(entry + T + 3 - cyc);
        end_cycle(7'h42, 1'b1);
        tick(5);

        // Abort: FCS_n rises together with the ack; DTACK_n never asserts.
        start_cycle(7'h40, 1'b1, entry);
        tick(entry + 2 - cyc);
        FCS_n     = 1'b1;
        NCR_ACK_n = 1'b0;
        push(cyc + 3, 1'b0, 1'b1, 1'b1, 1'b0, 7'h40, 1'b1);
        tick(4);
        NCR_ACK_n = 1'b1;
        DS_n      = 4'hF;
        tick(4);

        // Write at the top of the window completes normally.
        start_cycle(7'h43, 1'b0, entry);
        tick(entry + 2 - cyc);
        NCR_ACK_n = 1'b0;
        push(cyc + 3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h43, 1'b0);
        tick(5);
        end_cycle(7'h43, 1'b0);
        tick(5);

        // Reset while in ACK with DTACK_n low.
        start_cycle(7'h41, 1'b1, entry);
        tick(entry + 1 - cyc);
        NCR_ACK_n = 1'b0;
        push(cyc + 3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h41, 1'b1);
        tick(5);
        push(cyc, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
        #1;
        RESET = 1'b1;
        #1;
        check("async_rst_dtack_n", 32'(DTACK_n), 32'd1);
        check("async_rst_slave_cycle", 32'(slave_cycle), 32'd0);
        check("async_rst_ncr_cs_n", 32'(NCR_CS_n), 32'd1);
        RESET = 1'b0;

        // FCS_n still low after reset: no cycle may start.
        tick(10);
        FCS_n     = 1'b1;
        DS_n      = 4'hF;
        NCR_ACK_n = 1'b1;
        tick(5);

        // Fresh falling edge is accepted again.
        start_cycle(7'h42, 1'b0, entry);
        tick(entry + 1 - cyc);
        NCR_ACK_n = 1'b0;
        push(cyc + 3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h42, 1'b0);
        tick(5);
        end_cycle(7'h42, 1'b0);
        tick(6);

        check("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/zorro_slave_ctrl.md
# zorro_slave_ctrl

Zorro III slave-cycle controller for the A4092 card. It synchronises the host strobes, latches the cycle address and direction at the start of each cycle, and decodes the SCSI register region. It sequences the NCR chip-select / acknowledge handshake and returns DTACK_n to the host. Its `slave_cycle`, `read_latched` and `addr_latched` outputs feed the downstream buffer-enable/direction logic directly.

## Interface
- `TIMEOUT_CYCLES`, default 64: CLK cycles allowed in NCR_ACCESS before a forced DTACK. Legal range 2..255.
- `CLK` in 1: card clock; all state updates on rising edge.
- `RESET` in 1: reset, **asynchronous, active-high**. Forces every output to its reset value immediately.
- `FCS_n` in 1: Zorro full cycle strobe, asynchronous to CLK.
- `DS_n` in 4: Zorro data strobes, asynchronous to CLK.
- `READ` in 1: Zorro direction, 1 = host read.
- `ADDR` in 7: Zorro address bits [23:17].
- `configured` in 1: autoconfig complete.
- `NCR_ACK_n` in 1: NCR slave acknowledge, asynchronous to CLK.
- `slave_cycle` out 1: a decoded SCSI-region cycle is in progress.
- `read_latched` out 1: READ captured at cycle start.
- `addr_latched` out 7: ADDR captured at cycle start.
- `NCR_CS_n` out 1: NCR chip select.
- `DTACK_n` out 1: Zorro data transfer acknowledge.
- `timeout` out 1: one-cycle pulse when an access is force-terminated.

## Operation
- Synchronisers:
  - `FCS_n`, the AND of `DS_n` (any strobe low counts as asserted) and `NCR_ACK_n` each pass through a 2-flop synchroniser. Sync flops reset to 1.
  - `fcs_fall` = synced FCS_n low while the previous synced value was high.
- Region decode: `configured` = 1 and 0x40 ≤ ADDR ≤ 0x43, compared as 7-bit unsigned.
- IDLE:
  - All outputs inactive.
  - On `fcs_fall` with region hit: capture ADDR into `addr_latched` and READ into `read_latched`, set `slave_cycle` = 1, go to WAIT_DS.
  - On a region miss: stay in IDLE; nothing is latched.
- WAIT_DS:
  - Synced DS asserted: set NCR_CS_n = 0, clear the timeout counter, go to NCR_ACCESS.
  - Synced FCS_n high: go to IDLE (abort).
- NCR_ACCESS:
  - The counter increments every cycle.
  - Synced NCR_ACK_n low: set DTACK_n = 0, go to ACK.
  - Counter reaches TIMEOUT_CYCLES−1 with no ack: set DTACK_n = 0, pulse `timeout` for 1 cycle, go to ACK.
  - Synced FCS_n high: go to IDLE (abort). Abort takes priority over ack and over timeout in the same cycle.
- ACK:
  - Hold DTACK_n = 0, NCR_CS_n = 0 and `slave_cycle` = 1.
  - When synced FCS_n goes high: go to IDLE and deassert all outputs.
- Entering IDLE from any state deasserts `slave_cycle`, NCR_CS_n and DTACK_n on the same edge. `addr_latched` and `read_latched` hold their last value.
- A new `fcs_fall` is accepted only in IDLE. A back-to-back cycle needs FCS_n seen high for at least one synced sample.

## Timing
- Reset values:
  - `slave_cycle` = 0, `read_latched` = 0, `addr_latched` = 0x00.
  - NCR_CS_n = 1, DTACK_n = 1, `timeout` = 0.
  - State = IDLE, counter = 0.
- FCS_n first sampled low at edge N: `slave_cycle` is high after edge N+2.
- ADDR and READ must be stable from edge N through edge N+2.
- DS_n sampled low at edge M, with state WAIT_DS: NCR_CS_n is low after edge M+2.
- NCR_ACK_n sampled low at edge K: DTACK_n is low after edge K+2.
- Timeout: DTACK_n falls exactly TIMEOUT_CYCLES edges after the NCR_ACCESS entry edge. `timeout` is high for that one cycle.
- FCS_n sampled high at edge R, with state ACK: all outputs inactive after edge R+2.
- RESET asserted mid-cycle: outputs take reset values without waiting for CLK. After release the block returns to IDLE and waits for a fresh FCS_n fall.

## Test plan
- Read hit: configured = 1, ADDR = 0x41, READ = 1, FCS_n low, DS_n = 0x0, NCR_ACK_n low 5 cycles after NCR_CS_n falls.
  - Required: `slave_cycle` at N+2, `addr_latched` = 0x41, `read_latched` = 1.
  - Required: DTACK_n low 2 cycles after ack; all outputs released 2 cycles after FCS_n rises.
- Region miss:
  - ADDR = 0x44 (and separately ADDR = 0x40 with configured = 0), FCS_n low → `slave_cycle`, NCR_CS_n and DTACK_n stay 1 throughout.
- Timeout: TIMEOUT_CYCLES = 8, NCR_ACK_n held high.
  - Required: DTACK_n low exactly 8 edges after NCR_ACCESS entry, one-cycle `timeout` pulse.
  - Required: release on FCS_n rise.
- Abort: FCS_n raised while in NCR_ACCESS, in the same cycle as synced NCR_ACK_n falls.
  - Required: DTACK_n never asserts and the block returns to IDLE. Then a write cycle (READ = 0, ADDR = 0x43) completes normally with `read_latched` = 0.
- Reset mid-op: RESET pulsed while in ACK with DTACK_n = 0.
  - Required: DTACK_n = 1 and `slave_cycle` = 0 before the next CLK edge.
  - Required: no new cycle starts until FCS_n is seen high, then low again.
